// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
// Width and wait defaults mirror the core-wide register bus settings.
package wb_arbiter_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int REG_DATA_W   = 32;
  localparam int MAX_WAIT_DEF = 4;
  localparam int AGE_W        = 4;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_EX,
    GNT_LSU,
    GNT_DIV
  } gnt_e;

  typedef enum logic {
    RR_LSU = 1'b0,
    RR_DIV = 1'b1
  } rr_e;

endpackage

// File: rtl/wb_arbiter_hold_slot.sv
// One-entry holding slot for a slow write-back producer.
// Tracks how long the entry has waited, saturating at MAX_WAIT.
module wb_hold_slot
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              grant,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  output logic              valid,
  output logic              aged,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0] age;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
      age   <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      addr  <= cap_addr;
      data  <= cap_data;
      age   <= '0;
    end else if (grant) begin
      valid <= 1'b0;
      age   <= '0;
    end else if (valid && age != AGE_MAX) begin
      age <= age + 1'b1;
    end
  end

  assign aged = valid && (age >= AGE_MAX);

endmodule

// File: rtl/wb_arbiter.sv
// Merges execute, load/store and divider writes into one register-file port.
// Execute has priority; the slow producers share a round-robin pointer.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              ex_stall_o,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_waddr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  input  logic              div_valid_i,
  output logic              div_ready_o,
  input  logic [ADDR_W-1:0] div_waddr_i,
  input  logic [DATA_W-1:0] div_wdata_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              busy_o
);

  logic              lsu_v, lsu_aged;
  logic              div_v, div_aged;
  logic [ADDR_W-1:0] lsu_a, div_a;
  logic [DATA_W-1:0] lsu_d, div_d;

  logic              ex_take;
  gnt_e              gnt;
  rr_e               rr_q, rr_d;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              we_q, stall_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  wb_hold_slot #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_lsu_slot (
    .clk     (clk),
    .rst     (rst),
    .capture (lsu_valid_i & ~lsu_v),
    .grant   (gnt == GNT_LSU),
    .cap_addr(lsu_waddr_i),
    .cap_data(lsu_wdata_i),
    .valid   (lsu_v),
    .aged    (lsu_aged),
    .addr    (lsu_a),
    .data    (lsu_d)
  );

  wb_hold_slot #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_div_slot (
    .clk     (clk),
    .rst     (rst),
    .capture (div_valid_i & ~div_v),
    .grant   (gnt == GNT_DIV),
    .cap_addr(div_waddr_i),
    .cap_data(div_wdata_i),
    .valid   (div_v),
    .aged    (div_aged),
    .addr    (div_a),
    .data    (div_d)
  );

  // A stalled execute beat is a protocol error and is simply dropped.
  assign ex_take = ex_valid_i & ~stall_q;

  always_comb begin
    gnt  = GNT_NONE;
    rr_d = rr_q;
    unique case (1'b1)
      ex_take: gnt = GNT_EX;
      ~ex_take & lsu_v & div_v: begin
        gnt  = (rr_q == RR_LSU) ? GNT_LSU : GNT_DIV;
        rr_d = (rr_q == RR_LSU) ? RR_DIV : RR_LSU;
      end
      ~ex_take & lsu_v & ~div_v: gnt = GNT_LSU;
      ~ex_take & ~lsu_v & div_v: gnt = GNT_DIV;
      default: gnt = GNT_NONE;
    endcase
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    unique case (gnt)
      GNT_EX: begin
        sel_addr = ex_waddr_i;
        sel_data = ex_wdata_i;
      end
      GNT_LSU: begin
        sel_addr = lsu_a;
        sel_data = lsu_d;
      end
      GNT_DIV: begin
        sel_addr = div_a;
        sel_data = div_d;
      end
      default: begin
        sel_addr = '0;
        sel_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q    <= RR_LSU;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      stall_q <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      stall_q <= lsu_aged | div_aged;
      we_q    <= (gnt != GNT_NONE) && (sel_addr != '0);
      if (gnt != GNT_NONE) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
    end
  end

  assign we_o        = we_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign ex_stall_o  = stall_q;
  assign lsu_ready_o = ~lsu_v;
  assign div_ready_o = ~div_v;
  assign busy_o      = lsu_v | div_v;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scenario bench for wb_arbiter: directed cases plus random traffic
// compared against a cycle-level behavioural model.
module tb_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid = 1'b0;
  logic [AW-1:0] ex_waddr = '0;
  logic [DW-1:0] ex_wdata = '0;
  logic          ex_stall_o;
  logic          lsu_valid = 1'b0;
  logic          lsu_ready_o;
  logic [AW-1:0] lsu_waddr = '0;
  logic [DW-1:0] lsu_wdata = '0;
  logic          div_valid = 1'b0;
  logic          div_ready_o;
  logic [AW-1:0] div_waddr = '0;
  logic [DW-1:0] div_wdata = '0;
  logic          we_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MAX_WAIT(MW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid_i (ex_valid),
    .ex_waddr_i (ex_waddr),
    .ex_wdata_i (ex_wdata),
    .ex_stall_o (ex_stall_o),
    .lsu_valid_i(lsu_valid),
    .lsu_ready_o(lsu_ready_o),
    .lsu_waddr_i(lsu_waddr),
    .lsu_wdata_i(lsu_wdata),
    .div_valid_i(div_valid),
    .div_ready_o(div_ready_o),
    .div_waddr_i(div_waddr),
    .div_wdata_i(div_wdata),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .busy_o     (busy_o)
  );

  // Advance one clock; flags any execute beat offered during a stall.
  task automatic tick();
    if (ex_valid && ex_stall_o) begin
      errors++;
      $display("FAIL ex_protocol got ex_valid=1 with stall=1 want 0");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid  = 1'b0;
    lsu_valid = 1'b0;
    div_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    lsu_valid = 1'b1; lsu_waddr = 5'd3; lsu_wdata = 32'h33;
    div_valid = 1'b1; div_waddr = 5'd4; div_wdata = 32'h44;
    ex_valid  = 1'b1; ex_waddr  = 5'd9; ex_wdata  = 32'h99;
    tick();
    lsu_valid = 1'b0;
    div_valid = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || we_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_prefill busy=%b we=%b want 1 1", busy_o, we_o);
    end
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (we_o !== 1'b0 || ex_stall_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async we=%b stall=%b busy=%b want 0 0 0",
               we_o, ex_stall_o, busy_o);
    end
    checks++;
    if (lsu_ready_o !== 1'b1 || div_ready_o !== 1'b1
        || waddr_o !== '0 || wdata_o !== '0) begin
      errors++;
      $display("FAIL reset_ready lrdy=%b drdy=%b wa=%0d wd=%h want 1 1 0 0",
               lsu_ready_o, div_ready_o, waddr_o, wdata_o);
    end
    ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (we_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_after cyc=%0d we=%b busy=%b want 0 0",
                 i, we_o, busy_o);
      end
    end
  endtask

  task automatic test_ex_only();
    do_reset();
    ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h1234;
    tick();
    ex_valid = 1'b0;
    checks++;
    if (we_o !== 1'b1 || waddr_o !== 5'd5 || wdata_o !== 32'h1234) begin
      errors++;
      $display("FAIL ex_only we=%b wa=%0d wd=%h want 1 5 1234",
               we_o, waddr_o, wdata_o);
    end
    tick();
    checks++;
    if (we_o !== 1'b0) begin
      errors++;
      $display("FAIL ex_idle we=%b want 0", we_o);
    end
  endtask

  task automatic test_x0_drop();
    do_reset();
    lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'hDEAD;
    tick();
    lsu_valid = 1'b0;
    checks++;
    if (we_o !== 1'b0 || lsu_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL x0_held we=%b rdy=%b busy=%b want 0 0 1",
               we_o, lsu_ready_o, busy_o);
    end
    tick();
    checks++;
    if (we_o !== 1'b0 || lsu_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL x0_clear we=%b rdy=%b busy=%b want 0 1 0",
               we_o, lsu_ready_o, busy_o);
    end
    tick();
    checks++;
    if (we_o !== 1'b0) begin
      errors++;
      $display("FAIL x0_after we=%b want 0", we_o);
    end
  endtask

  task automatic rr_pair(input logic [AW-1:0] la, input logic [DW-1:0] ld,
                         input logic [AW-1:0] da, input logic [DW-1:0] dd,
                         input logic [AW-1:0] fa, input logic [DW-1:0] fd,
                         input logic [AW-1:0] sa, input logic [DW-1:0] sd);
    lsu_valid = 1'b1; lsu_waddr = la; lsu_wdata = ld;
    div_valid = 1'b1; div_waddr = da; div_wdata = dd;
    tick();
    lsu_valid = 1'b0;
    div_valid = 1'b0;
    tick();
    checks++;
    if (we_o !== 1'b1 || waddr_o !== fa || wdata_o !== fd) begin
      errors++;
      $display("FAIL rr_first we=%b wa=%0d wd=%h want 1 %0d %h",
               we_o, waddr_o, wdata_o, fa, fd);
    end
    tick();
    checks++;
    if (we_o !== 1'b1 || waddr_o !== sa || wdata_o !== sd) begin
      errors++;
      $display("FAIL rr_second we=%b wa=%0d wd=%h want 1 %0d %h",
               we_o, waddr_o, wdata_o, sa, sd);
    end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    rr_pair(5'd1, 32'hA, 5'd2, 32'hB, 5'd1, 32'hA, 5'd2, 32'hB);
    rr_pair(5'd3, 32'hC, 5'd4, 32'hD, 5'd4, 32'hD, 5'd3, 32'hC);
  endtask

  task automatic test_starvation();
    logic want_stall;
    do_reset();
    ex_valid  = 1'b1; ex_waddr  = 5'd10; ex_wdata = 32'h100;
    lsu_valid = 1'b1; lsu_waddr = 5'd7;  lsu_wdata = 32'h77;
    tick();
    lsu_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      ex_valid = ~ex_stall_o;
      ex_waddr = AW'(10 + k);
      ex_wdata = 32'h100 + k;
      tick();
      want_stall = (k == MW + 1) || (k == MW + 2);
      checks++;
      if (ex_stall_o !== want_stall) begin
        errors++;
        $display("FAIL starve_stall k=%0d got %b want %b",
                 k, ex_stall_o, want_stall);
      end
      if (k == MW + 2) begin
        checks++;
        if (we_o !== 1'b1 || waddr_o !== 5'd7 || wdata_o !== 32'h77) begin
          errors++;
          $display("FAIL starve_write we=%b wa=%0d wd=%h want 1 7 77",
                   we_o, waddr_o, wdata_o);
        end
      end
    end
    ex_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int nw = 0;
    int last_hs = -1;
    logic hs;
    do_reset();
    lsu_valid = 1'b1; lsu_waddr = 5'd20; lsu_wdata = 32'h1000;
    for (int c = 0; c < 20; c++) begin
      hs = lsu_valid && lsu_ready_o;
      tick();
      if (hs) begin
        if (last_hs >= 0) begin
          checks++;
          if (c - last_hs !== 2) begin
            errors++;
            $display("FAIL b2b_rate gap=%0d want 2", c - last_hs);
          end
        end
        last_hs = c;
        idx++;
        if (idx == 4) lsu_valid = 1'b0;
        lsu_waddr = AW'(20 + idx);
        lsu_wdata = 32'h1000 + idx;
      end
      if (lsu_ready_o === busy_o) begin
        errors++;
        $display("FAIL b2b_ready rdy=%b busy=%b want opposite",
                 lsu_ready_o, busy_o);
      end
      if (we_o) begin
        checks++;
        if (waddr_o !== AW'(20 + nw) || wdata_o !== 32'h1000 + nw) begin
          errors++;
          $display("FAIL b2b_order wa=%0d wd=%h want %0d %h",
                   waddr_o, wdata_o, 20 + nw, 32'h1000 + nw);
        end
        nw++;
      end
    end
    checks++;
    if (nw !== 4) begin
      errors++;
      $display("FAIL b2b_count got %0d want 4", nw);
    end
  endtask

  // Random traffic; the model tracks pending entries and waiting time.
  task automatic test_random();
    logic          mv[2];
    logic [AW-1:0] ma[2];
    logic [DW-1:0] md[2];
    int            mwait[2];
    int            pref;
    int            g;
    logic          mstall, nstall, mwe;
    logic [AW-1:0] mwa;
    logic [DW-1:0] mwd;
    logic          lrdy, drdy;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      mv[s] = 1'b0; ma[s] = '0; md[s] = '0; mwait[s] = 0;
    end
    pref = 0; mstall = 1'b0; mwe = 1'b0; mwa = '0; mwd = '0;
    for (int c = 0; c < 400; c++) begin
      ex_valid  = !mstall && ($urandom_range(0, 9) < 6);
      ex_waddr  = AW'($urandom);
      ex_wdata  = $urandom;
      lsu_valid = ($urandom_range(0, 2) == 0);
      lsu_waddr = AW'($urandom);
      lsu_wdata = $urandom;
      div_valid = ($urandom_range(0, 3) == 0);
      div_waddr = AW'($urandom);
      div_wdata = $urandom;
      lrdy = !mv[0];
      drdy = !mv[1];
      nstall = (mv[0] && mwait[0] >= MW) || (mv[1] && mwait[1] >= MW);
      g = -1;
      if (ex_valid && !mstall) g = 2;
      else if (mv[0] && mv[1]) begin g = pref; pref = 1 - pref; end
      else if (mv[0]) g = 0;
      else if (mv[1]) g = 1;
      if (g == 2) begin mwa = ex_waddr; mwd = ex_wdata; end
      else if (g >= 0) begin mwa = ma[g]; mwd = md[g]; end
      mwe = (g >= 0) && (mwa != '0);
      for (int s = 0; s < 2; s++) begin
        if (g == s) mv[s] = 1'b0;
        else if (mv[s]) mwait[s]++;
      end
      if (lsu_valid && lrdy) begin
        mv[0] = 1'b1; ma[0] = lsu_waddr; md[0] = lsu_wdata; mwait[0] = 0;
      end
      if (div_valid && drdy) begin
        mv[1] = 1'b1; ma[1] = div_waddr; md[1] = div_wdata; mwait[1] = 0;
      end
      mstall = nstall;
      tick();
      checks++;
      if (we_o !== mwe || waddr_o !== mwa || wdata_o !== mwd) begin
        errors++;
        $display("FAIL rand_write c=%0d got %b %0d %h want %b %0d %h",
                 c, we_o, waddr_o, wdata_o, mwe, mwa, mwd);
      end
      checks++;
      if (ex_stall_o !== mstall || busy_o !== (mv[0] | mv[1])
          || lsu_ready_o !== !mv[0] || div_ready_o !== !mv[1]) begin
        errors++;
        $display("FAIL rand_ctrl c=%0d got st=%b bz=%b lr=%b dr=%b want %b %b %b %b",
                 c, ex_stall_o, busy_o, lsu_ready_o, div_ready_o,
                 mstall, mv[0] | mv[1], !mv[0], !mv[1]);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_ex_only();
    test_x0_drop();
    test_round_robin();
    test_starvation();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
